// File: rtl/ckegen_pkg.sv
// Shared types and helpers for the clock-enable generator/monitor family.
package ckegen_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_LOCK
  } ckemon_state_t;

  // Counter width able to hold 0..2*T inclusive.
  function automatic int ckemon_width(input int t);
    return $clog2(2 * t + 1);
  endfunction

endpackage

// File: rtl/ckemon_redge.sv
// Rising-edge detector: registers the input and flags a low-to-high transition
// in the same cycle the input goes high.
module redge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_edge
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  // A strobe already high right after reset counts as an edge, since d_q resets low.
  assign q_edge = d & ~d_q;

endmodule

// File: rtl/ckemon.sv
// Clock-enable period monitor: measures strobe period, declares lock after
// LOCK_N consecutive in-tolerance periods, flags bad periods and timeouts.
module ckemon
  import ckegen_pkg::*;
#(
  parameter int  T      = 50000000,
  parameter int  TOL    = 1,
  parameter int  LOCK_N = 4,
  localparam int W      = ckemon_width(T)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cke,
  output logic [W-1:0] period,
  output logic         period_vld,
  output logic         locked,
  output logic         err
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [W-1:0]  P_LO   = W'(T - TOL);
  localparam logic [W-1:0]  P_HI   = W'(T + TOL);
  localparam logic [W-1:0]  P_MAX  = W'(2 * T);
  localparam logic [MW-1:0] M_LOCK = MW'(LOCK_N);

  ckemon_state_t state, state_d;
  logic [W-1:0]  cnt, cnt_d, period_d;
  logic [MW-1:0] mcnt, mcnt_d;
  logic          vld_d, err_d, locked_d;
  logic          cke_edge, in_tol, timeout;

  redge u_redge (
    .clk    (clk),
    .rst    (rst),
    .d      (cke),
    .q_edge (cke_edge)
  );

  assign in_tol  = (cnt >= P_LO) && (cnt <= P_HI);
  assign timeout = (cnt == P_MAX);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    mcnt_d   = mcnt;
    period_d = period;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cke_edge) begin
          state_d = S_MEAS;
          cnt_d   = W'(1);
          mcnt_d  = '0;
        end else begin
          cnt_d = '0;
        end
      end
      S_MEAS, S_LOCK: begin
        // An edge wins over a simultaneous timeout; 2T is then reported as a bad period.
        if (cke_edge) begin
          cnt_d    = W'(1);
          period_d = cnt;
          vld_d    = 1'b1;
          if (in_tol) begin
            if (state == S_MEAS) begin
              mcnt_d = mcnt + MW'(1);
              if (mcnt_d == M_LOCK) state_d = S_LOCK;
            end
          end else begin
            err_d   = 1'b1;
            mcnt_d  = '0;
            state_d = S_MEAS;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
          mcnt_d  = '0;
        end else begin
          cnt_d = cnt + W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        mcnt_d  = '0;
      end
    endcase
    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mcnt       <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      mcnt       <= mcnt_d;
      period     <= period_d;
      period_vld <= vld_d;
      err        <= err_d;
      locked     <= locked_d;
    end
  end

endmodule

// File: tb/tb_ckemon.sv
// Directed bench for ckemon with T=8, TOL=1, LOCK_N=4: table of strobe edges
// with expected outputs, plus hand-written timeout and async-reset sequences.
module tb_ckemon;

  localparam int T = 8;
  localparam int W = $clog2(2 * T + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cke = 1'b0;
  logic [W-1:0] period;
  logic         period_vld, locked, err;

  int n_checks = 0;
  int n_fail   = 0;

  ckemon #(.T(T), .TOL(1), .LOCK_N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cke        (cke),
    .period     (period),
    .period_vld (period_vld),
    .locked     (locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  // One edge record: optional reset first, then a rising edge, expected outputs
  // for that edge, and the high width / distance to the next edge.
  typedef struct {
    logic rst_before;
    int   hi;
    int   gap;
    logic vld;
    int   per;
    logic lck;
    logic er;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input int hi, input int gap,
                              input logic v, input int p, input logic l, input logic e);
    vec_t x;
    x.rst_before = r; x.hi = hi; x.gap = gap;
    x.vld = v; x.per = p; x.lck = l; x.er = e;
    tbl.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply v for one cycle; returns 1 time unit after the closing clock edge.
  task automatic tick(input logic v);
    cke = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_vld"}, 32'(period_vld), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"}, 32'(err), 0);
    cke = 1'b0;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
  endtask

  task automatic run(input vec_t v, input string tag);
    bit quiet = 1'b1;
    if (v.rst_before) do_reset({tag, "_rst"});
    tick(1'b1);
    check({tag, "_vld"}, 32'(period_vld), 32'(v.vld));
    if (v.vld) check({tag, "_period"}, 32'(period), 32'(v.per));
    check({tag, "_locked"}, 32'(locked), 32'(v.lck));
    check({tag, "_err"}, 32'(err), 32'(v.er));
    for (int i = 1; i < v.gap; i++) begin
      tick(i < v.hi);
      if (period_vld || err) quiet = 1'b0;
    end
    if (v.gap > 1) check({tag, "_quiet"}, 32'(quiet), 1);
  endtask

  initial begin
    bit quiet;
    // Pulse strobe from reset, bad period 10, relock, edge coinciding with timeout.
    add(1, 1, 8,  0, 0,  0, 0);
    add(0, 1, 8,  1, 8,  0, 0);
    add(0, 1, 8,  1, 8,  0, 0);
    add(0, 1, 8,  1, 8,  0, 0);
    add(0, 1, 8,  1, 8,  1, 0);
    add(0, 1, 10, 1, 8,  1, 0);
    add(0, 1, 8,  1, 10, 0, 1);
    add(0, 1, 8,  1, 8,  0, 0);
    add(0, 1, 8,  1, 8,  0, 0);
    add(0, 1, 8,  1, 8,  0, 0);
    add(0, 1, 16, 1, 8,  1, 0);
    add(0, 1, 8,  1, 16, 0, 1);
    add(0, 1, 0,  1, 8,  0, 0);
    // Alternating 7/9 periods, all in tolerance.
    add(1, 1, 7,  0, 0,  0, 0);
    add(0, 1, 9,  1, 7,  0, 0);
    add(0, 1, 7,  1, 9,  0, 0);
    add(0, 1, 9,  1, 7,  0, 0);
    add(0, 1, 7,  1, 9,  1, 0);
    add(0, 1, 0,  1, 7,  1, 0);
    // Multi-cycle level strobe (4 high, 4 low).
    add(1, 4, 8,  0, 0,  0, 0);
    add(0, 4, 8,  1, 8,  0, 0);
    add(0, 4, 8,  1, 8,  0, 0);
    add(0, 4, 8,  1, 8,  0, 0);
    add(0, 4, 0,  1, 8,  1, 0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // Locked, then strobe held low: timeout exactly 16 cycles after last edge.
    quiet = 1'b1;
    for (int i = 1; i < 2 * T; i++) begin
      tick(1'b0);
      if (period_vld || err) quiet = 1'b0;
    end
    check("to_quiet", 32'(quiet), 1);
    tick(1'b0);
    check("to_err", 32'(err), 1);
    check("to_locked", 32'(locked), 0);
    check("to_vld", 32'(period_vld), 0);

    // Back in idle: first edge reports nothing, then relock after 4 periods.
    run('{0, 1, 8, 0, 0, 0, 0}, "post_to0");
    run('{0, 1, 8, 1, 8, 0, 0}, "post_to1");
    run('{0, 1, 8, 1, 8, 0, 0}, "post_to2");
    run('{0, 1, 8, 1, 8, 0, 0}, "post_to3");
    run('{0, 1, 3, 1, 8, 1, 0}, "post_to4");

    // Async reset mid-lock, then lock again from scratch.
    run('{1, 1, 8, 0, 0, 0, 0}, "post_rst0");
    run('{0, 1, 8, 1, 8, 0, 0}, "post_rst1");
    run('{0, 1, 8, 1, 8, 0, 0}, "post_rst2");
    run('{0, 1, 8, 1, 8, 0, 0}, "post_rst3");
    run('{0, 1, 0, 1, 8, 1, 0}, "post_rst4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
